// File: rtl/lamp_pkg.sv
// Shared definitions for the lamp safety monitor:
// state encodings, fault codes, lamp bit positions.
package lamp_pkg;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_FAILSAFE   = 2'd1,
        ST_CLEAR_WAIT = 2'd2
    } state_t;

    localparam logic [2:0] FC_NONE      = 3'd0;
    localparam logic [2:0] FC_CONFLICT  = 3'd1;
    localparam logic [2:0] FC_DARK      = 3'd2;
    localparam logic [2:0] FC_MULTI     = 3'd3;
    localparam logic [2:0] FC_STUCK     = 3'd4;
    localparam logic [2:0] FC_SHORT_YEL = 3'd5;

    localparam int EW_RED    = 5;
    localparam int EW_YELLOW = 4;
    localparam int EW_GREEN  = 3;
    localparam int NS_RED    = 2;
    localparam int NS_YELLOW = 1;
    localparam int NS_GREEN  = 0;

    // Bit positions inside one 3-bit approach slice
    localparam int APP_RED = 2;
    localparam int APP_YEL = 1;
    localparam int APP_GRN = 0;

    localparam logic [5:0] ALL_RED  = 6'b100100;
    localparam logic [5:0] ALL_DARK = 6'b000000;

    typedef struct packed {
        logic dark;
        logic multi;
        logic short_yel;
    } app_flags_t;

    function automatic logic [1:0] lit_count(input logic [2:0] l);
        lit_count = {1'b0, l[APP_RED]}
                  + {1'b0, l[APP_YEL]}
                  + {1'b0, l[APP_GRN]};
    endfunction

endpackage

// File: rtl/approach_check.sv
// Per-approach lamp checks: dark / multi-lit decode
// and the yellow-duration counter for short-yellow detection.
module approach_check
    import lamp_pkg::*;
#(
    parameter int MIN_YELLOW = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       primed,
    input  logic       tick_1hz,
    input  logic [2:0] lamps,
    output app_flags_t flags
);

    localparam int YW = $clog2(MIN_YELLOW + 2);
    localparam logic [YW-1:0] YMAX = YW'(MIN_YELLOW);

    logic [YW-1:0] ycnt;
    logic          prev_yel;
    logic          yel;

    assign yel = lamps[APP_YEL];

    // Only "reached MIN_YELLOW or not" matters, so saturate there
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            ycnt <= '0;
        end else if (!yel) begin
            ycnt <= '0;
        end else if (tick_1hz && ycnt != YMAX) begin
            ycnt <= ycnt + YW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_yel <= 1'b0;
        end else begin
            prev_yel <= yel;
        end
    end

    assign flags.dark      = (lamps == 3'b000);
    assign flags.multi     = (lit_count(lamps) > 2'd1);
    assign flags.short_yel = primed && prev_yel && !yel
                          && (ycnt < YMAX);

endmodule

// File: rtl/lamp_safety_monitor.sv
// Traffic-lamp safety monitor: passes controller lamps through,
// trips to flashing red on conflict, dark, multi-lit, stuck or short yellow.
module lamp_safety_monitor
    import lamp_pkg::*;
#(
    parameter int FAULT_PERSIST = 2,
    parameter int MAX_STUCK     = 20,
    parameter int MIN_YELLOW    = 3,
    parameter int FLASH_HALF    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic [5:0] lamp_in,
    input  logic       fault_clr,
    output logic [5:0] lamp_out,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [1:0] mode
);

    localparam int PW = $clog2(FAULT_PERSIST + 1);
    localparam int SW = $clog2(MAX_STUCK + 2);
    localparam int FW = $clog2(FLASH_HALF + 1);

    localparam logic [PW-1:0] PMAX = PW'(FAULT_PERSIST);
    localparam logic [SW-1:0] SMAX = SW'(MAX_STUCK + 1);
    localparam logic [FW-1:0] FMAX = FW'(FLASH_HALF);

    state_t        state;
    logic [PW-1:0] pcnt;
    logic [PW-1:0] pcnt_nxt;
    logic [SW-1:0] scnt;
    logic [SW-1:0] scnt_nxt;
    logic [FW-1:0] fcnt;
    logic [FW-1:0] fcnt_nxt;
    logic          flash_on;
    logic          flash_nxt;
    logic [5:0]    prev_lamp;
    logic          primed;

    app_flags_t ew_f;
    app_flags_t ns_f;

    logic       conflict;
    logic       dark;
    logic       multi;
    logic       viol;
    logic       changed;
    logic       persist_decl;
    logic       stuck_decl;
    logic       short_decl;
    logic       declare;
    logic [2:0] cause;
    logic       run_entry;

    approach_check #(
        .MIN_YELLOW(MIN_YELLOW)
    ) u_ew (
        .clk      (clk),
        .rst      (rst),
        .clr      (run_entry),
        .primed   (primed),
        .tick_1hz (tick_1hz),
        .lamps    (lamp_in[EW_RED:EW_GREEN]),
        .flags    (ew_f)
    );

    approach_check #(
        .MIN_YELLOW(MIN_YELLOW)
    ) u_ns (
        .clk      (clk),
        .rst      (rst),
        .clr      (run_entry),
        .primed   (primed),
        .tick_1hz (tick_1hz),
        .lamps    (lamp_in[NS_RED:NS_GREEN]),
        .flags    (ns_f)
    );

    assign conflict = (lamp_in[EW_YELLOW] | lamp_in[EW_GREEN])
                    & (lamp_in[NS_YELLOW] | lamp_in[NS_GREEN]);
    assign dark     = ew_f.dark | ns_f.dark;
    assign multi    = ew_f.multi | ns_f.multi;
    assign viol     = conflict | dark | multi;
    assign changed  = primed && (lamp_in != prev_lamp);

    always_comb begin
        pcnt_nxt = '0;
        if (viol) begin
            pcnt_nxt = (pcnt == PMAX) ? PMAX : pcnt + PW'(1);
        end
    end

    always_comb begin
        scnt_nxt = scnt;
        if (changed) begin
            scnt_nxt = '0;
        end else if (tick_1hz && scnt != SMAX) begin
            scnt_nxt = scnt + SW'(1);
        end
    end

    // Declarations look at this cycle's counts so the trip lands on this edge
    assign persist_decl = viol && (pcnt_nxt == PMAX);
    assign stuck_decl   = (scnt_nxt == SMAX);
    assign short_decl   = ew_f.short_yel | ns_f.short_yel;
    assign declare      = persist_decl | stuck_decl | short_decl;

    always_comb begin
        cause = FC_NONE;
        if (persist_decl) begin
            if (conflict) begin
                cause = FC_CONFLICT;
            end else if (dark) begin
                cause = FC_DARK;
            end else begin
                cause = FC_MULTI;
            end
        end else if (stuck_decl) begin
            cause = FC_STUCK;
        end else if (short_decl) begin
            cause = FC_SHORT_YEL;
        end
    end

    assign run_entry = (state == ST_CLEAR_WAIT) && !declare
                    && (lamp_in == ALL_RED) && !fault_clr;

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt      <= '0;
            scnt      <= '0;
            prev_lamp <= '0;
            primed    <= 1'b0;
        end else begin
            prev_lamp <= lamp_in;
            primed    <= 1'b1;
            if (run_entry) begin
                pcnt <= '0;
                scnt <= '0;
            end else begin
                pcnt <= pcnt_nxt;
                scnt <= scnt_nxt;
            end
        end
    end

    always_comb begin
        fcnt_nxt  = fcnt;
        flash_nxt = flash_on;
        if (tick_1hz) begin
            if (fcnt + FW'(1) >= FMAX) begin
                fcnt_nxt  = '0;
                flash_nxt = !flash_on;
            end else begin
                fcnt_nxt = fcnt + FW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_CLEAR_WAIT;
            lamp_out   <= ALL_RED;
            fault_code <= FC_NONE;
            fcnt       <= '0;
            flash_on   <= 1'b0;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (declare) begin
                        state      <= ST_FAILSAFE;
                        fault_code <= cause;
                        lamp_out   <= ALL_RED;
                        fcnt       <= '0;
                        flash_on   <= 1'b1;
                    end else begin
                        lamp_out <= lamp_in;
                    end
                end
                ST_FAILSAFE: begin
                    if (fault_clr) begin
                        state    <= ST_CLEAR_WAIT;
                        lamp_out <= ALL_RED;
                    end else begin
                        fcnt     <= fcnt_nxt;
                        flash_on <= flash_nxt;
                        lamp_out <= flash_nxt ? ALL_RED : ALL_DARK;
                    end
                end
                ST_CLEAR_WAIT: begin
                    if (declare) begin
                        state      <= ST_FAILSAFE;
                        fault_code <= cause;
                        lamp_out   <= ALL_RED;
                        fcnt       <= '0;
                        flash_on   <= 1'b1;
                    end else if (run_entry) begin
                        state      <= ST_RUN;
                        fault_code <= FC_NONE;
                        lamp_out   <= lamp_in;
                    end else begin
                        lamp_out <= ALL_RED;
                    end
                end
                default: begin
                    state    <= ST_CLEAR_WAIT;
                    lamp_out <= ALL_RED;
                end
            endcase
        end
    end

    assign fault = (state != ST_RUN);
    assign mode  = state;

endmodule

// File: tb/tb_lamp_safety_monitor.sv
// Bench for lamp_safety_monitor: directed vector table,
// multi-cycle corner sequences, random stimulus against a model.
module tb_lamp_safety_monitor;

    localparam int FP = 2;
    localparam int MS = 20;
    localparam int MY = 3;
    localparam int FH = 1;
    localparam logic [5:0] RED2 = 6'b100100;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic [5:0] lamp_in;
    logic       clr;
    logic [5:0] lamp_out;
    logic       fault;
    logic [2:0] fault_code;
    logic [1:0] mode;

    lamp_safety_monitor #(
        .FAULT_PERSIST(FP),
        .MAX_STUCK    (MS),
        .MIN_YELLOW   (MY),
        .FLASH_HALF   (FH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_1hz   (tick),
        .lamp_in    (lamp_in),
        .fault_clr  (clr),
        .lamp_out   (lamp_out),
        .fault      (fault),
        .fault_code (fault_code),
        .mode       (mode)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: mode 0=RUN 1=FAILSAFE 2=CLEAR_WAIT
    int         m_mode;
    logic [5:0] m_out;
    int         m_code;
    bit         m_lit;
    int         m_ft;
    int         m_vrun;
    int         m_st;
    int         m_yt [2];
    logic [5:0] m_prev;
    bit         m_primed;

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_step(input bit r, input bit t, input bit c,
                              input logic [5:0] l);
        logic [2:0] app [2];
        logic [2:0] pa  [2];
        bit c1, c2, c3, viol, chg, pdecl, sdecl, sy;
        int code;
        if (r) begin
            m_mode = 2; m_out = RED2; m_code = 0;
            m_lit = 0; m_ft = 0; m_vrun = 0; m_st = 0;
            m_yt[0] = 0; m_yt[1] = 0;
            m_prev = '0; m_primed = 0;
        end else begin
            app[0] = l[5:3];      app[1] = l[2:0];
            pa[0]  = m_prev[5:3]; pa[1]  = m_prev[2:0];
            c1 = (app[0][1] || app[0][0]) && (app[1][1] || app[1][0]);
            c2 = (app[0] == 3'b000) || (app[1] == 3'b000);
            c3 = ($countones(app[0]) > 1) || ($countones(app[1]) > 1);
            viol = c1 || c2 || c3;
            m_vrun = viol ? imin(m_vrun + 1, FP) : 0;
            pdecl = viol && (m_vrun >= FP);
            chg = m_primed && (l != m_prev);
            m_st = chg ? 0 : imin(m_st + int'(t), MS + 1);
            sdecl = (m_st > MS);
            sy = 0;
            for (int a = 0; a < 2; a++) begin
                if (m_primed && pa[a][1] && !app[a][1] && m_yt[a] < MY)
                    sy = 1;
                m_yt[a] = app[a][1] ? imin(m_yt[a] + int'(t), MY) : 0;
            end
            code = pdecl ? (c1 ? 1 : (c2 ? 2 : 3))
                 : sdecl ? 4 : sy ? 5 : 0;
            m_prev = l;
            m_primed = 1;
            if (m_mode != 1 && code != 0) begin
                m_mode = 1; m_code = code; m_out = RED2;
                m_lit = 1; m_ft = 0;
            end else if (m_mode == 0) begin
                m_out = l;
            end else if (m_mode == 1) begin
                if (c) begin
                    m_mode = 2;
                    m_out = RED2;
                end else begin
                    if (t) begin
                        m_ft++;
                        if (m_ft >= FH) begin
                            m_lit = !m_lit;
                            m_ft = 0;
                        end
                    end
                    m_out = m_lit ? RED2 : 6'b000000;
                end
            end else if (l == RED2 && !c) begin
                m_mode = 0; m_code = 0; m_out = l;
                m_vrun = 0; m_st = 0; m_yt[0] = 0; m_yt[1] = 0;
            end else begin
                m_out = RED2;
            end
        end
    endtask

    task automatic check(input string name, input logic [5:0] e_out,
                         input logic e_f, input logic [2:0] e_code,
                         input logic [1:0] e_mode);
        n_tests++;
        if (lamp_out !== e_out || fault !== e_f ||
            fault_code !== e_code || mode !== e_mode) begin
            n_fail++;
            $display("FAIL %s: got out=%b fault=%b code=%0d mode=%0d, want out=%b fault=%b code=%0d mode=%0d",
                     name, lamp_out, fault, fault_code, mode,
                     e_out, e_f, e_code, e_mode);
        end
    endtask

    task automatic drive(input bit r, input bit t, input bit c,
                         input logic [5:0] l);
        rst = r; tick = t; clr = c; lamp_in = l;
        model_step(r, t, c, l);
        @(posedge clk);
        #1;
    endtask

    task automatic step(input bit r, input bit t, input bit c,
                        input logic [5:0] l, input string name);
        drive(r, t, c, l);
        check(name, m_out, (m_mode != 0), 3'(m_code), 2'(m_mode));
    endtask

    typedef struct {
        bit         r;
        bit         t;
        bit         c;
        logic [5:0] l;
        logic [5:0] out;
        bit         f;
        logic [2:0] code;
        logic [1:0] mode;
    } vec_t;

    vec_t tbl [$];

    task automatic add(input bit r, input bit t, input bit c,
                       input logic [5:0] l, input logic [5:0] o,
                       input bit f, input int code, input int md);
        vec_t v;
        v.r = r; v.t = t; v.c = c; v.l = l; v.out = o;
        v.f = f; v.code = 3'(code); v.mode = 2'(md);
        tbl.push_back(v);
    endtask

    logic [5:0] legal [6];
    logic [5:0] cur;

    initial begin
        add(1,0,0, 6'b100100, 6'b100100, 1, 0, 2);
        add(0,0,0, 6'b100100, 6'b100100, 0, 0, 0);
        add(0,0,0, 6'b100001, 6'b100001, 0, 0, 0);
        add(0,0,0, 6'b001001, 6'b001001, 0, 0, 0);
        add(0,0,0, 6'b100001, 6'b100001, 0, 0, 0);
        add(0,0,0, 6'b001001, 6'b001001, 0, 0, 0);
        add(0,0,0, 6'b001001, 6'b100100, 1, 1, 1);
        add(0,1,0, 6'b001001, 6'b000000, 1, 1, 1);
        add(0,0,0, 6'b001001, 6'b000000, 1, 1, 1);
        add(0,1,0, 6'b001001, 6'b100100, 1, 1, 1);
        add(0,0,1, 6'b100100, 6'b100100, 1, 1, 2);
        add(0,0,0, 6'b100100, 6'b100100, 0, 0, 0);
        add(0,0,0, 6'b000001, 6'b000001, 0, 0, 0);
        add(0,0,0, 6'b000001, 6'b100100, 1, 2, 1);
        add(0,0,1, 6'b100100, 6'b100100, 1, 2, 2);
        add(0,0,0, 6'b100100, 6'b100100, 0, 0, 0);
        add(0,0,0, 6'b110100, 6'b110100, 0, 0, 0);
        add(0,0,0, 6'b110100, 6'b100100, 1, 3, 1);
        add(0,0,1, 6'b100100, 6'b100100, 1, 3, 2);
        add(0,0,1, 6'b100100, 6'b100100, 1, 3, 2);
        add(0,0,0, 6'b100100, 6'b100100, 0, 0, 0);
        add(0,0,0, 6'b011001, 6'b011001, 0, 0, 0);
        add(0,0,0, 6'b011001, 6'b100100, 1, 1, 1);
        add(1,0,0, 6'b011001, 6'b100100, 1, 0, 2);
        add(0,0,0, 6'b100100, 6'b100100, 0, 0, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].t, tbl[i].c, tbl[i].l);
            check($sformatf("vec%0d", i), tbl[i].out, tbl[i].f,
                  tbl[i].code, tbl[i].mode);
        end

        // NS yellow held for 3 ticks is legal
        step(0,0,0, 6'b100001, "yok_g");
        for (int i = 0; i < 7; i++)
            step(0, bit'(i % 2), 0, 6'b100010, "yok_y");
        step(0,0,0, 6'b100100, "yok_r");
        check("yel_ok", 6'b100100, 0, 3'd0, 2'd0);

        // NS yellow dropped after only 2 ticks
        step(0,0,0, 6'b100001, "ysh_g");
        for (int i = 0; i < 4; i++)
            step(0, bit'(i % 2), 0, 6'b100010, "ysh_y");
        step(0,0,0, 6'b100100, "ysh_r");
        check("yel_short", 6'b100100, 1, 3'd5, 2'd1);
        step(0,0,1, 6'b100100, "ysh_clr");
        check("yel_clr_wait", 6'b100100, 1, 3'd5, 2'd2);
        step(0,0,0, 6'b100100, "ysh_run");
        check("yel_run", 6'b100100, 0, 3'd0, 2'd0);

        // Pattern held unchanged for MAX_STUCK+1 ticks
        step(0,0,0, 6'b100001, "stk_chg");
        for (int i = 1; i <= 21; i++) begin
            step(0,0,0, 6'b100001, "stk_hold");
            step(0,1,0, 6'b100001, "stk_tick");
            if (i == 20)
                check("stuck_20", 6'b100001, 0, 3'd0, 2'd0);
        end
        check("stuck_21", 6'b100100, 1, 3'd4, 2'd1);
        step(0,0,1, 6'b100100, "stk_clr");
        step(0,0,0, 6'b100100, "stk_run");
        check("stuck_run", 6'b100100, 0, 3'd0, 2'd0);

        legal[0] = 6'b100001; legal[1] = 6'b100010;
        legal[2] = 6'b100100; legal[3] = 6'b001100;
        legal[4] = 6'b010100; legal[5] = 6'b100100;
        cur = RED2;
        for (int i = 0; i < 4000; i++) begin
            bit r, t, c;
            int span;
            span = ((i / 500) % 2 == 1) ? 127 : 7;
            if ($urandom_range(0, span) == 0)
                cur = ($urandom_range(0, 9) == 0) ? 6'($urandom)
                                                   : legal[$urandom_range(0, 5)];
            t = ($urandom_range(0, 3) == 0);
            c = ($urandom_range(0, 15) == 0);
            r = ($urandom_range(0, 999) == 0);
            step(r, t, c, cur, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
